// File: rtl/ofdm_pkg.sv
// Shared OFDM datapath constants, sample field slices and a counter-width helper.
// Used by cp_remove and the other streaming stages.
package ofdm_pkg;

   localparam int N_FFT_DEF   = 256;
   localparam int CP_LEN_DEF  = 32;
   localparam int SYM_LEN_DEF = N_FFT_DEF + CP_LEN_DEF;

   localparam int SAMPLE_W = 32;
   localparam int RE_LSB   = 0;
   localparam int RE_MSB   = 15;
   localparam int IM_LSB   = 16;
   localparam int IM_MSB   = 31;

   // Smallest w with 2^w >= n (at least 1).
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

   function automatic logic [15:0] sample_re(input logic [SAMPLE_W-1:0] s);
      return s[RE_MSB:RE_LSB];
   endfunction

   function automatic logic [15:0] sample_im(input logic [SAMPLE_W-1:0] s);
      return s[IM_MSB:IM_LSB];
   endfunction

endpackage

// File: rtl/wb_stream_oreg.sv
// Output register stage for a Wishbone-style stream: holds data/valid while the
// downstream stalls (o_halt = o_stb & ~i_ack), otherwise loads the new sample.
module wb_stream_oreg #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_dat,
   input  logic         i_vld,
   input  logic         i_ack,
   output logic [W-1:0] o_dat,
   output logic         o_stb,
   output logic         o_halt
);

   logic [W-1:0] r_dat;
   logic         r_stb;

   assign o_halt = r_stb & ~i_ack;
   assign o_dat  = r_dat;
   assign o_stb  = r_stb;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dat <= '0;
         r_stb <= 1'b0;
      end else if (!o_halt) begin
         r_stb <= i_vld;
         if (i_vld) r_dat <= i_dat;
      end
   end

endmodule

// File: rtl/cp_remove.sv
// OFDM receive cyclic-prefix removal: drops CP_LEN prefix samples per symbol and
// forwards the N_FFT body. Optional LAST_O port under macro CP_REMOVE_LAST_EN.
module cp_remove
   import ofdm_pkg::*;
#(
   parameter int N_FFT  = N_FFT_DEF,
   parameter int CP_LEN = CP_LEN_DEF,
   parameter int CNT_W  = cnt_width(SYM_LEN_DEF)
) (
   input  logic                CLK_I,
   input  logic                RST_I,
   input  logic [SAMPLE_W-1:0] DAT_I,
   input  logic                CYC_I,
   input  logic                WE_I,
   input  logic                STB_I,
   output logic                ACK_O,
   output logic [SAMPLE_W-1:0] DAT_O,
   output logic                CYC_O,
   output logic                STB_O,
   output logic                WE_O,
   input  logic                ACK_I,
`ifdef CP_REMOVE_LAST_EN
   output logic                LAST_O,
`endif
   output logic [15:0]         SYM_CNT_O
);

   localparam int SYM_LEN = N_FFT + CP_LEN;
   localparam logic [CNT_W-1:0] CP_IDX   = CNT_W'(CP_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYM_LEN - 1);

   logic [CNT_W-1:0] r_s_cnt;
   logic             r_icyc;
   logic             r_cyc_o;
   logic [15:0]      r_sym_cnt;

   logic             w_ena;
   logic             w_halt;
   logic             w_ack;
   logic             w_start;
   logic [CNT_W-1:0] w_idx;
   logic             w_keep;
   logic             w_vld;
   logic             w_sym_end;
   logic             w_stb;

   assign w_ena   = CYC_I & STB_I & WE_I;
   assign w_ack   = w_ena & ~w_halt;
   assign w_start = CYC_I & ~r_icyc;

   // A sample accepted on the burst's first cycle is index 0 regardless of r_s_cnt.
   assign w_idx     = w_start ? '0 : r_s_cnt;
   assign w_keep    = (w_idx >= CP_IDX);
   assign w_vld     = w_ack & w_keep;
   assign w_sym_end = w_ack & (w_idx == LAST_IDX);

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_s_cnt <= '0;
         r_icyc  <= 1'b0;
      end else begin
         r_icyc <= CYC_I;
         if (w_start)
            r_s_cnt <= w_ack ? CNT_W'(1) : '0;
         else if (w_ack)
            r_s_cnt <= (r_s_cnt == LAST_IDX) ? '0 : r_s_cnt + CNT_W'(1);
      end
   end

   wb_stream_oreg #(.W(SAMPLE_W)) u_oreg (
      .i_clk  (CLK_I),
      .i_rst  (RST_I),
      .i_dat  (DAT_I),
      .i_vld  (w_vld),
      .i_ack  (ACK_I),
      .o_dat  (DAT_O),
      .o_stb  (w_stb),
      .o_halt (w_halt)
   );

   // Burst flag rises with the first forwarded sample; falls once input burst
   // has ended and nothing is left pending downstream.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_cyc_o   <= 1'b0;
         r_sym_cnt <= '0;
      end else begin
         if (w_vld)
            r_cyc_o <= 1'b1;
         else if (!CYC_I && !w_stb)
            r_cyc_o <= 1'b0;
         if (w_sym_end)
            r_sym_cnt <= r_sym_cnt + 16'd1;
      end
   end

`ifdef CP_REMOVE_LAST_EN
   logic r_last;

   always_ff @(posedge CLK_I) begin
      if (RST_I)
         r_last <= 1'b0;
      else if (!w_halt)
         r_last <= w_sym_end;
   end

   assign LAST_O = r_last;
`endif

   assign ACK_O     = w_ack;
   assign STB_O     = w_stb;
   assign WE_O      = w_stb;
   assign CYC_O     = r_cyc_o;
   assign SYM_CNT_O = r_sym_cnt;

endmodule
